mod_exp_param: RTL and testbench

MOD_EXP_PARAM -- requirements
Module: mod_exp_param

---
 rtl/mod_exp_param.sv | 199 +++++++++++++++++++
 tb/tb_mod_exp_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_param.sv
// ---------------------------------------------------------------------------
// mod_exp_param
//
// Purpose:
//   Computes U = M^E mod N with right-to-left binary exponentiation. Each
//   exponent bit costs one MUL phase (WIDTH cycles) and one UPDATE cycle.
//   In the MUL phase two interleaved MSB-first modular multipliers run side
//   by side: R*B mod N and B*B mod N.
//
// Parameters:
//   WIDTH      bit width of M, N and U (minimum 4)
//   EXP_WIDTH  bit width of E (minimum 1)
//
// Ports:
//   clk     single clock, rising edge
//   rst     synchronous active-high reset, higher priority than start
//   start   request pulse, sampled only in IDLE
//   M, E, N base, exponent and modulus, captured in the start cycle
//   U       result, held until the next accepted start
//   finish  one-cycle completion pulse
//   busy    high from the cycle after an accepted start through finish
//   err     operand error (N < 2 or M >= N), valid with finish and held
//
// Configuration:
//   MODEXP_EARLY_EXIT_EN  when defined, the loop stops once no set exponent
//                         bits remain. The result is unchanged, only the
//                         latency is shorter.
// ---------------------------------------------------------------------------
module mod_exp_param #(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     M,
  input  logic [EXP_WIDTH-1:0] E,
  input  logic [WIDTH-1:0]     N,
  output logic [WIDTH-1:0]     U,
  output logic                 finish,
  output logic                 busy,
  output logic                 err
);

  localparam int PW  = WIDTH + 2;
  localparam int MCW = $clog2(WIDTH);
  localparam int BCW = $clog2(EXP_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, UPDATE, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     n_reg;
  logic [WIDTH-1:0]     r_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [EXP_WIDTH-1:0] x_reg;
  logic [WIDTH-1:0]     a_rb;
  logic [WIDTH-1:0]     a_bb;
  logic [PW-1:0]        p_rb;
  logic [PW-1:0]        p_bb;
  logic [MCW-1:0]       mul_cnt;
  logic [BCW-1:0]       bit_cnt;

  // One interleaved multiplier step. If p and b are below n, the result is
  // also below n. The extra two bits of width hold 2p and p+b without
  // overflow.
  function automatic logic [PW-1:0] mm_step(input logic [PW-1:0] p,
                                            input logic          abit,
                                            input logic [PW-1:0] b,
                                            input logic [PW-1:0] n);
    logic [PW-1:0] t;
    t = p << 1;
    if (t >= n) t = t - n;
    if (abit) t = t + b;
    if (t >= n) t = t - n;
    return t;
  endfunction

  // Next values for the multiplier accumulators and the UPDATE-phase
  // results. They are computed combinationally so that the state machine
  // only selects which of them to register.
  logic [PW-1:0]        p_rb_next;
  logic [PW-1:0]        p_bb_next;
  logic [WIDTH-1:0]     r_new;
  logic [WIDTH-1:0]     b_new;
  logic [EXP_WIDTH-1:0] x_shift;
  logic                 last_bit;

  always_comb begin
    p_rb_next = mm_step(p_rb, a_rb[WIDTH-1], {2'b00, b_reg}, {2'b00, n_reg});
    p_bb_next = mm_step(p_bb, a_bb[WIDTH-1], {2'b00, b_reg}, {2'b00, n_reg});
    r_new     = x_reg[0] ? p_rb[WIDTH-1:0] : r_reg;
    b_new     = p_bb[WIDTH-1:0];
    x_shift   = x_reg >> 1;
`ifdef MODEXP_EARLY_EXIT_EN
    last_bit  = (bit_cnt == BCW'(EXP_WIDTH - 1)) || (x_shift == '0);
`else
    last_bit  = (bit_cnt == BCW'(EXP_WIDTH - 1));
`endif
  end

  // Main control FSM. All outputs are registered here.
  // In IDLE, M is captured straight into B and E straight into X. LOAD
  // therefore only has to validate the operands and set R to 1.
  // The a_* registers are shifting copies of the multiplier operands. Their
  // MSB supplies the current multiplier bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      U       <= '0;
      finish  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      n_reg   <= '0;
      r_reg   <= '0;
      b_reg   <= '0;
      x_reg   <= '0;
      a_rb    <= '0;
      a_bb    <= '0;
      p_rb    <= '0;
      p_bb    <= '0;
      mul_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b_reg <= M;
            x_reg <= E;
            n_reg <= N;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          if ((n_reg < WIDTH'(2)) || (b_reg >= n_reg)) begin
            err    <= 1'b1;
            finish <= 1'b1;
            state  <= DONE;
`ifdef MODEXP_EARLY_EXIT_EN
          end else if (x_reg == '0) begin
            r_reg  <= WIDTH'(1);
            U      <= WIDTH'(1);
            finish <= 1'b1;
            state  <= DONE;
`endif
          end else begin
            r_reg   <= WIDTH'(1);
            a_rb    <= WIDTH'(1);
            a_bb    <= b_reg;
            p_rb    <= '0;
            p_bb    <= '0;
            mul_cnt <= '0;
            bit_cnt <= '0;
            state   <= MUL;
          end
        end

        MUL: begin
          p_rb    <= p_rb_next;
          p_bb    <= p_bb_next;
          a_rb    <= a_rb << 1;
          a_bb    <= a_bb << 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == MCW'(WIDTH - 1)) state <= UPDATE;
        end

        UPDATE: begin
          r_reg   <= r_new;
          b_reg   <= b_new;
          x_reg   <= x_shift;
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            U      <= r_new;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            a_rb    <= r_new;
            a_bb    <= b_new;
            p_rb    <= '0;
            p_bb    <= '0;
            mul_cnt <= '0;
            state   <= MUL;
          end
        end

        DONE: begin
          finish <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_param.sv
// ---------------------------------------------------------------------------
// tb_mod_exp_param
//
// Bench for mod_exp_param with WIDTH = EXP_WIDTH = 16. Each accepted request
// pushes its expected result, error flag and finish cycle into a queue. A
// monitor pops the queue on every finish pulse. The reference result comes
// from plain square-and-multiply arithmetic.
// ---------------------------------------------------------------------------
module tb_mod_exp_param;

  localparam int W  = 16;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  M;
  logic [EW-1:0] E;
  logic [W-1:0]  N;
  logic [W-1:0]  U;
  logic          finish;
  logic          busy;
  logic          err;

  mod_exp_param #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .M      (M),
    .E      (E),
    .N      (N),
    .U      (U),
    .finish (finish),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Cycle number: the cycle whose start level the next rising edge samples.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] u;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_u = '0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act,
               expv, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m,
                                              input logic [EW-1:0] e,
                                              input logic [W-1:0] n);
    longint unsigned r  = 1;
    longint unsigned b  = longint'(m);
    longint unsigned nn = longint'(n);
    longint unsigned ee = longint'(e);
    b = b % nn;
    while (ee != 0) begin
      if (ee[0]) r = (r * b) % nn;
      b  = (b * b) % nn;
      ee = ee >> 1;
    end
    return r[W-1:0];
  endfunction

  function automatic int exp_latency(input logic is_err, input logic [EW-1:0] e);
    int k;
    if (is_err) return 2;
`ifdef MODEXP_EARLY_EXIT_EN
    k = 0;
    for (int i = 0; i < EW; i++) if (e[i]) k = i + 1;
`else
    k = EW;
`endif
    return 2 + k * (W + 1);
  endfunction

  // Monitor: every finish pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (finish) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_finish", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        checkOutput("result_U", 64'(U), 64'(x.u));
        checkOutput("err_flag", 64'(err), 64'(x.err));
        checkOutput("finish_cycle", 64'(cyc), 64'(x.cyc));
        checkOutput("busy_at_finish", 64'(busy), 64'd1);
      end
    end
  end

  // Waits for IDLE, then issues one request and records its expected
  // outcome. With holdFinish set, a bogus start is driven in the finish
  // cycle; the DUT must ignore it. With spurious set, random starts with
  // garbage operands are driven while the DUT is busy.
  task automatic applyStimulus(input logic [W-1:0] m, input logic [EW-1:0] e,
                               input logic [W-1:0] n, input bit holdFinish,
                               input bit spurious, output int c);
    int   guard = 0;
    exp_t x;
    while (busy && guard < 3000) begin
      if ((holdFinish && finish) || (spurious && $urandom_range(0, 7) == 0)) begin
        start = 1'b1;
        M = W'($urandom);
        E = EW'($urandom);
        N = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) checkOutput("idle_timeout", 64'd1, 64'd0);
    M = m; E = e; N = n; start = 1'b1;
    c = cyc;
    x.err = (n < 2) || (m >= n);
    x.u   = x.err ? last_u : ref_modexp(m, e, n);
    x.cyc = c + exp_latency(x.err, e);
    last_u = x.u;
    sb.push_back(x);
    @(posedge clk); #1;
    start = 1'b0;
    M = W'($urandom);
    E = EW'($urandom);
    N = W'($urandom);
  endtask

  // Waits, with a bound, until every pending expectation has been popped.
  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Directed sequence first, then randomized runs.
  initial begin
    int           c;
    logic [W-1:0] rm, rn;
    logic [EW-1:0] re;
    logic [EW-1:0] rst_e;

    rst = 1'b1; start = 1'b0; M = '0; E = '0; N = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_U", 64'(U), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_finish", 64'(finish), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    rst = 1'b0;

    applyStimulus(16'd4, 16'd13, 16'd497, 1'b0, 1'b0, c);
    applyStimulus(16'd2, 16'd10, 16'd1000, 1'b0, 1'b0, c);
    applyStimulus(16'd3, 16'd5, 16'd7, 1'b1, 1'b0, c);
    applyStimulus(16'd9, 16'd0, 16'd11, 1'b0, 1'b0, c);
    applyStimulus(16'd5, 16'd3, 16'd1, 1'b0, 1'b0, c);
    applyStimulus(16'd20, 16'd3, 16'd17, 1'b0, 1'b0, c);
    drain();

    // Reset in the middle of a run. Under early exit a longer exponent keeps
    // the run alive past cycle 100.
`ifdef MODEXP_EARLY_EXIT_EN
    rst_e = 16'h800D;
`else
    rst_e = 16'd13;
`endif
    applyStimulus(16'd4, rst_e, 16'd497, 1'b0, 1'b0, c);
    while (cyc < c + 100) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
    checkOutput("midrun_reset_U", 64'(U), 64'd0);
    checkOutput("midrun_reset_finish", 64'(finish), 64'd0);
    last_u = '0;
    repeat (300) @(posedge clk);
    #1;
    applyStimulus(16'd4, 16'd13, 16'd497, 1'b0, 1'b0, c);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 19) == 0) rn = W'($urandom_range(0, 1));
      else rn = W'($urandom_range(2, 65535));
      if ($urandom_range(0, 9) == 0) rm = W'($urandom_range(int'(rn), 65535));
      else rm = (rn == 0) ? '0 : W'($urandom % int'(rn));
      if ($urandom_range(0, 3) == 0) re = EW'($urandom_range(0, 15));
      else re = EW'($urandom_range(0, 65535));
      applyStimulus(rm, re, rn, bit'($urandom_range(0, 1)), 1'b1, c);
    end
    drain();
    checkOutput("final_idle_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
